// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle main control unit.
//   - opcode constants for the supported instruction subset
//   - controller state enum (exported on state_o for debug)
//   - ALU-op, ALU B-source and PC-source encodings
package ctrl_pkg;

    localparam int CTRL_OP_W    = 6;
    localparam int CTRL_ALUOP_W = 2;
    localparam int CTRL_STATE_W = 4;

    localparam logic [CTRL_OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [CTRL_OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [CTRL_OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [CTRL_OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [CTRL_OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [CTRL_OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [CTRL_OP_W-1:0] OP_J     = 6'h02;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_RWB    = 4'd7,
        S_IMMEX  = 4'd8,
        S_IMMWB  = 4'd9,
        S_BEQ    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 2'd0;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 2'd1;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SLT   = 2'd3;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style main control for the multi-cycle datapath.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives
// the datapath enables and mux selects for the current state.
// Ports:
//   clk_i, rst_i (async, active-high)   clock and reset
//   instr_op_i [OP_W]                   opcode held in the instruction register
//   mem_ready_i                         memory completes the access this cycle
//   pc_write_o, pc_write_cond_o, pc_src_o[2]   PC update control
//   iord_o, mem_read_o, mem_write_o            memory interface control
//   ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o   IR / register file control
//   alu_src_a_o, alu_src_b_o[2], alu_op_o[ALUOP_W]     ALU operand / op selects
//   illegal_o                           pulse in DECODE for unsupported opcode
//   state_o [STATE_W]                   current state, debug only
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int STATE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_src_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               mem_to_reg_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    state_t state, state_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= state_nxt;
    end

    assign state_o = STATE_W'(state);

    // Outputs follow the state; only the FETCH ready-gating and the opcode
    // terms in DECODE/MEMADR/IMMEX look at inputs.
    always_comb begin
        state_nxt       = state;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = PCSRC_ALU;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_REG;
        alu_op_o        = ALUOP_W'(ALUOP_ADD);
        illegal_o       = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                // IR and PC only load on the cycle the read actually completes.
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b_o = SRCB_IMM_SH;
                case (instr_op_i)
                    OP_RTYPE:        state_nxt = S_RTYPE;
                    OP_LW, OP_SW:    state_nxt = S_MEMADR;
                    OP_ADDI, OP_SLTI: state_nxt = S_IMMEX;
                    OP_BEQ:          state_nxt = S_BEQ;
                    OP_J:            state_nxt = S_JUMP;
                    default: begin
                        state_nxt = S_FETCH;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                state_nxt   = (instr_op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) state_nxt = S_FETCH;
            end
            S_RTYPE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_W'(ALUOP_FUNCT);
                state_nxt   = S_RWB;
            end
            S_RWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = (instr_op_i == OP_SLTI) ? ALUOP_W'(ALUOP_SLT)
                                                      : ALUOP_W'(ALUOP_ADD);
                state_nxt   = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write_o = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_W'(ALUOP_SUB);
                pc_write_cond_o = 1'b1;
                pc_src_o        = PCSRC_ALUOUT;
                state_nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PCSRC_JUMP;
                state_nxt  = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each supported instruction class
// through the controller and compares control outputs against hand-derived values.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instr_op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl #(.OP_W(6), .ALUOP_W(2), .STATE_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(instr_op), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .pc_src_o(pc_src),
        .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
        .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op), .illegal_o(illegal), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All four write enables packed: {reg_write, mem_write, pc_write, ir_write}
    function automatic logic [7:0] wen();
        return {4'b0, reg_write, mem_write, pc_write, ir_write};
    endfunction

    initial begin
        rst = 1'b1; instr_op = 6'h00; mem_ready = 1'b0;
        #1;
        // Reset state
        chk("rst_state", state, S_FETCH);
        chk("rst_mem_read", mem_read, 1);
        chk("rst_alu_src_b", alu_src_b, 1);
        chk("rst_wen", wen(), 0);
        chk("rst_others", {pc_write_cond, pc_src, iord, mem_to_reg, reg_dst, alu_src_a, alu_op, illegal}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_rel_state", state, S_FETCH);
        chk("rst_rel_wen", wen(), 0);

        // R-type, ready tied high: FETCH DECODE RTYPE RWB
        mem_ready = 1'b1; instr_op = 6'h00; #1;
        chk("r_fetch_state", state, S_FETCH);
        chk("r_fetch_wen", wen(), 8'b0011);
        tick();
        chk("r_dec_state", state, S_DECODE);
        chk("r_dec_srcb", alu_src_b, 3);
        chk("r_dec_wen", wen(), 0);
        tick();
        chk("r_ex_state", state, S_RTYPE);
        chk("r_ex_aluop", alu_op, 2);
        chk("r_ex_srca_srcb", {alu_src_a, alu_src_b}, 8'b100);
        chk("r_ex_wen", wen(), 0);
        tick();
        chk("r_wb_state", state, S_RWB);
        chk("r_wb_wen", wen(), 8'b1000);
        chk("r_wb_dst_m2r", {reg_dst, mem_to_reg}, 8'b10);
        tick();
        chk("r_done_state", state, S_FETCH);

        // lw with 3 wait cycles in MEMRD
        instr_op = 6'h23;
        tick();
        chk("lw_dec_state", state, S_DECODE);
        tick();
        chk("lw_adr_state", state, S_MEMADR);
        chk("lw_adr_sel", {alu_src_a, alu_src_b, alu_op}, 8'b11000);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lw_rd_state", state, S_MEMRD);
            chk("lw_rd_req", {mem_read, iord}, 8'b11);
            chk("lw_rd_wen", wen(), 0);
            if (i == 3) mem_ready = 1'b1;
        end
        tick();
        chk("lw_wb_state", state, S_MEMWB);
        chk("lw_wb_wen", wen(), 8'b1000);
        chk("lw_wb_m2r_dst", {mem_to_reg, reg_dst}, 8'b10);
        tick();
        chk("lw_done_state", state, S_FETCH);

        // sw
        instr_op = 6'h2B;
        tick(); tick();
        chk("sw_adr_state", state, S_MEMADR);
        tick();
        chk("sw_wr_state", state, S_MEMWR);
        chk("sw_wr_wen", wen(), 8'b0100);
        chk("sw_wr_iord", {iord, mem_read}, 8'b10);
        tick();
        chk("sw_done_state", state, S_FETCH);
        chk("sw_done_memwr", mem_write, 0);

        // beq
        instr_op = 6'h04;
        tick(); tick();
        chk("beq_state", state, S_BEQ);
        chk("beq_ctl", {pc_write_cond, alu_op, pc_src, alu_src_a, alu_src_b}, 8'b1_01_01_1_00);
        chk("beq_wen", wen(), 0);
        tick();
        chk("beq_done_state", state, S_FETCH);

        // j
        instr_op = 6'h02;
        tick(); tick();
        chk("j_state", state, S_JUMP);
        chk("j_ctl", {pc_write, pc_src, pc_write_cond}, 8'b1_10_0);
        chk("j_wen", wen(), 8'b0010);
        tick();
        chk("j_done_state", state, S_FETCH);

        // slti then addi
        instr_op = 6'h0A;
        tick(); tick();
        chk("slti_ex_state", state, S_IMMEX);
        chk("slti_ex_ctl", {alu_src_a, alu_src_b, alu_op}, 8'b1_10_11);
        tick();
        chk("slti_wb_state", state, S_IMMWB);
        chk("slti_wb_ctl", {reg_write, reg_dst, mem_to_reg}, 8'b100);
        tick();
        instr_op = 6'h08;
        tick(); tick();
        chk("addi_ex_state", state, S_IMMEX);
        chk("addi_ex_ctl", {alu_src_a, alu_src_b, alu_op}, 8'b1_10_00);
        tick();
        chk("addi_wb_ctl", {reg_write, reg_dst, mem_to_reg}, 8'b100);
        tick();
        chk("addi_done_state", state, S_FETCH);

        // Illegal opcode
        instr_op = 6'h3F;
        chk("ill_fetch_illegal", illegal, 0);
        tick();
        chk("ill_dec_state", state, S_DECODE);
        chk("ill_dec_illegal", illegal, 1);
        chk("ill_dec_wen", wen(), 0);
        tick();
        chk("ill_back_state", state, S_FETCH);
        chk("ill_back_illegal", illegal, 0);

        // Reset pulse while waiting in MEMWR
        instr_op = 6'h2B;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        chk("rstwr_state", state, S_MEMWR);
        chk("rstwr_memwr", mem_write, 1);
        tick();
        chk("rstwr_hold_state", state, S_MEMWR);
        #2 rst = 1'b1;
        #1;
        chk("rstwr_async_state", state, S_FETCH);
        chk("rstwr_async_memwr", mem_write, 0);
        chk("rstwr_async_wen", wen(), 0);
        #2 rst = 1'b0;
        tick();
        chk("rstwr_rel_state", state, S_FETCH);
        chk("rstwr_rel_wen", wen(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
